// File: rtl/regfile_wb_arb.sv
// Write-port arbiter for the 32x32 register file: round-robin between ALU and
// LSU writeback, lowest-priority debug writes with a starvation guard.
module regfile_wb_arb #(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_addr,
  input  logic [31:0] alu_wb_data,
  output logic        alu_wb_ready,
  input  logic        lsu_wb_valid,
  input  logic [4:0]  lsu_wb_addr,
  input  logic [31:0] lsu_wb_data,
  output logic        lsu_wb_ready,
  input  logic        dbg_wb_valid,
  input  logic [4:0]  dbg_wb_addr,
  input  logic [31:0] dbg_wb_data,
  output logic        dbg_wb_ready,
  output logic        wen,
  output logic [4:0]  wraddr,
  output logic [31:0] wrdata,
  output logic        wb_conflict
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LSU,
    GNT_DBG
  } gnt_e;

  logic             rr_last;     // 0: ALU granted last, 1: LSU granted last
  logic [CNT_W-1:0] starve_cnt;
  gnt_e             gnt;
  logic             force_dbg;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic [1:0]       num_valid;

  // Grant selection and source mux
  always_comb begin
    gnt       = GNT_NONE;
    sel_addr  = '0;
    sel_data  = '0;
    force_dbg = dbg_wb_valid && (starve_cnt == CNT_W'(STARVE_MAX));
    if (rst) begin
      gnt = GNT_NONE;
    end else if (force_dbg) begin
      gnt = GNT_DBG;
    end else if (alu_wb_valid && lsu_wb_valid) begin
      gnt = rr_last ? GNT_ALU : GNT_LSU;
    end else if (alu_wb_valid) begin
      gnt = GNT_ALU;
    end else if (lsu_wb_valid) begin
      gnt = GNT_LSU;
    end else if (dbg_wb_valid) begin
      gnt = GNT_DBG;
    end
    case (gnt)
      GNT_ALU: begin sel_addr = alu_wb_addr; sel_data = alu_wb_data; end
      GNT_LSU: begin sel_addr = lsu_wb_addr; sel_data = lsu_wb_data; end
      GNT_DBG: begin sel_addr = dbg_wb_addr; sel_data = dbg_wb_data; end
      default: begin sel_addr = '0; sel_data = '0; end
    endcase
  end

  assign alu_wb_ready = (gnt == GNT_ALU);
  assign lsu_wb_ready = (gnt == GNT_LSU);
  assign dbg_wb_ready = (gnt == GNT_DBG);
  assign num_valid    = 2'(alu_wb_valid) + 2'(lsu_wb_valid) + 2'(dbg_wb_valid);

  // Arbitration state and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last     <= 1'b1;
      starve_cnt  <= '0;
      wen         <= 1'b0;
      wraddr      <= '0;
      wrdata      <= '0;
      wb_conflict <= 1'b0;
    end else begin
      if (gnt == GNT_ALU) rr_last <= 1'b0;
      else if (gnt == GNT_LSU) rr_last <= 1'b1;

      if (!dbg_wb_valid || gnt == GNT_DBG) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      wb_conflict <= (num_valid >= 2'd2);

      // x0 grants complete the handshake but never write
      if (gnt != GNT_NONE) begin
        wen    <= (sel_addr != '0);
        wraddr <= sel_addr;
        wrdata <= sel_data;
      end else begin
        wen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed vector table, starvation sequences and
// randomized traffic checked against a behavioural arbitration model.
module tb_regfile_wb_arb;

  localparam int STARVE_MAX = 8;

  typedef struct packed {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        dv;
    logic [4:0]  da;
    logic [31:0] dd;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic [2:0]  rdy;   // {dbg, lsu, alu}
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        conf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_wb_valid = 1'b0, lsu_wb_valid = 1'b0, dbg_wb_valid = 1'b0;
  logic [4:0]  alu_wb_addr = '0, lsu_wb_addr = '0, dbg_wb_addr = '0;
  logic [31:0] alu_wb_data = '0, lsu_wb_data = '0, dbg_wb_data = '0;
  logic        alu_wb_ready, lsu_wb_ready, dbg_wb_ready;
  logic        wen, wb_conflict;
  logic [4:0]  wraddr;
  logic [31:0] wrdata;

  regfile_wb_arb #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr),
    .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_addr(lsu_wb_addr),
    .lsu_wb_data(lsu_wb_data), .lsu_wb_ready(lsu_wb_ready),
    .dbg_wb_valid(dbg_wb_valid), .dbg_wb_addr(dbg_wb_addr),
    .dbg_wb_data(dbg_wb_data), .dbg_wb_ready(dbg_wb_ready),
    .wen(wen), .wraddr(wraddr), .wrdata(wrdata), .wb_conflict(wb_conflict)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: who won the last ALU/LSU tie, how long debug has waited
  bit          m_alu_last;
  int          m_wait;
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_conf;
  logic [2:0]  last_rdy;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_alu_last = 1'b0;
    m_wait = 0;
    m_wen = 1'b0; m_addr = '0; m_data = '0; m_conf = 1'b0;
  endtask

  // One clock: drive, check readies vs model, clock, check outputs vs model
  task automatic step(input in_t v);
    int g;   // 0 none, 1 alu, 2 lsu, 3 dbg
    logic [2:0] exp_rdy;
    @(negedge clk);
    rst = v.rst;
    alu_wb_valid = v.av; alu_wb_addr = v.aa; alu_wb_data = v.ad;
    lsu_wb_valid = v.lv; lsu_wb_addr = v.la; lsu_wb_data = v.ld;
    dbg_wb_valid = v.dv; dbg_wb_addr = v.da; dbg_wb_data = v.dd;
    #1;
    g = 0;
    if (v.rst) g = 0;
    else if (v.dv && m_wait >= STARVE_MAX) g = 3;
    else if (v.av && v.lv) g = m_alu_last ? 2 : 1;
    else if (v.av) g = 1;
    else if (v.lv) g = 2;
    else if (v.dv) g = 3;
    exp_rdy = (g == 0) ? 3'b000 : 3'(1 << (g - 1));
    last_rdy = {dbg_wb_ready, lsu_wb_ready, alu_wb_ready};
    chk("model_ready", 32'(last_rdy), 32'(exp_rdy));
    @(posedge clk);
    if (v.rst) begin
      model_reset();
    end else begin
      if (g == 1) m_alu_last = 1'b1;
      if (g == 2) m_alu_last = 1'b0;
      if (!v.dv || g == 3) m_wait = 0;
      else if (m_wait < STARVE_MAX) m_wait++;
      m_conf = (int'(v.av) + int'(v.lv) + int'(v.dv)) >= 2;
      m_wen = 1'b0;
      if (g != 0) begin
        m_addr = (g == 1) ? v.aa : (g == 2) ? v.la : v.da;
        m_data = (g == 1) ? v.ad : (g == 2) ? v.ld : v.dd;
        m_wen  = (m_addr != 0);
      end
    end
    #1;
    chk("model_wen", 32'(wen), 32'(m_wen));
    chk("model_wraddr", 32'(wraddr), 32'(m_addr));
    chk("model_wrdata", wrdata, m_data);
    chk("model_conflict", 32'(wb_conflict), 32'(m_conf));
  endtask

  function automatic in_t mk(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                             input logic lv, input logic [4:0] la, input logic [31:0] ld,
                             input logic dv, input logic [4:0] da, input logic [31:0] dd);
    in_t t;
    t.rst = r; t.av = av; t.aa = aa; t.ad = ad; t.lv = lv; t.la = la; t.ld = ld;
    t.dv = dv; t.da = da; t.dd = dd;
    return t;
  endfunction

  function automatic vec_t mv(input in_t i, input logic [2:0] rdy, input logic w,
                              input logic [4:0] wa, input logic [31:0] wd, input logic c);
    vec_t t;
    t.in = i; t.rdy = rdy; t.wen = w; t.wa = wa; t.wd = wd; t.conf = c;
    return t;
  endfunction

  vec_t vecs[$];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    in_t idle, rs, both, stv, cur;
    int  gi;
    bit  pa, pl, pd;

    model_reset();
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rs   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    both = mk(0, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 0, 0, 0);

    // Directed table: inputs and hand-derived expected readies/outputs
    vecs.push_back(mv(rs, 3'b000, 0, 5'd0, 32'h0, 0));
    vecs.push_back(mv(mk(0, 1, 5'd5, 32'h11223344, 0, 0, 0, 0, 0, 0), 3'b001, 1, 5'd5, 32'h11223344, 0));
    vecs.push_back(mv(idle, 3'b000, 0, 5'd5, 32'h11223344, 0));
    vecs.push_back(mv(rs, 3'b000, 0, 5'd0, 32'h0, 0));
    vecs.push_back(mv(both, 3'b001, 1, 5'd1, 32'hA, 1));
    vecs.push_back(mv(both, 3'b010, 1, 5'd2, 32'hB, 1));
    vecs.push_back(mv(both, 3'b001, 1, 5'd1, 32'hA, 1));
    vecs.push_back(mv(both, 3'b010, 1, 5'd2, 32'hB, 1));
    vecs.push_back(mv(idle, 3'b000, 0, 5'd2, 32'hB, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0), 3'b010, 0, 5'd0, 32'hFFFFFFFF, 0));
    vecs.push_back(mv(mk(1, 1, 5'd3, 32'h33, 0, 0, 0, 0, 0, 0), 3'b000, 0, 5'd0, 32'h0, 0));
    vecs.push_back(mv(mk(0, 1, 5'd3, 32'h33, 0, 0, 0, 0, 0, 0), 3'b001, 1, 5'd3, 32'h33, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h99), 3'b100, 1, 5'd9, 32'h99, 0));
    vecs.push_back(mv(mk(0, 1, 5'd4, 32'h44, 0, 0, 0, 1, 5'd9, 32'h99), 3'b001, 1, 5'd4, 32'h44, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in);
      chk($sformatf("vec%0d_ready", i), 32'(last_rdy), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_wen", i), 32'(wen), 32'(vecs[i].wen));
      chk($sformatf("vec%0d_wraddr", i), 32'(wraddr), 32'(vecs[i].wa));
      chk($sformatf("vec%0d_wrdata", i), wrdata, vecs[i].wd);
      chk($sformatf("vec%0d_conflict", i), 32'(wb_conflict), 32'(vecs[i].conf));
    end

    // Starvation: debug forced in on the 9th cycle, then the wait restarts from zero
    step(rs);
    stv = mk(0, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 1, 5'd7, 32'hDEAD);
    for (int rep = 0; rep < 2; rep++) begin
      gi = -1;
      for (int i = 0; i < 20; i++) begin
        step(stv);
        if (last_rdy[2]) begin
          gi = i;
          break;
        end
      end
      chk($sformatf("starve_grant_cycle%0d", rep), 32'(gi), 32'd8);
      chk($sformatf("starve_wraddr%0d", rep), 32'(wraddr), 32'd7);
      chk($sformatf("starve_wrdata%0d", rep), wrdata, 32'hDEAD);
    end
    step(idle);
    chk("idle_after_starve_wen", 32'(wen), 32'd0);
    chk("idle_hold_wraddr", 32'(wraddr), 32'd7);

    // Randomized traffic obeying the hold-until-accepted rule
    step(rs);
    pa = 0; pl = 0; pd = 0;
    cur = idle;
    for (int n = 0; n < 3000; n++) begin
      if (!pa && $urandom_range(0, 99) < 45) begin
        pa = 1; cur.aa = 5'($urandom_range(0, 31)); cur.ad = $urandom;
      end
      if (!pl && $urandom_range(0, 99) < 45) begin
        pl = 1; cur.la = 5'($urandom_range(0, 31)); cur.ld = $urandom;
      end
      if (!pd && $urandom_range(0, 99) < 30) begin
        pd = 1; cur.da = 5'($urandom_range(0, 31)); cur.dd = $urandom;
      end
      cur.av = pa; cur.lv = pl; cur.dv = pd;
      cur.rst = ($urandom_range(0, 199) == 0);
      step(cur);
      if (last_rdy[0]) pa = 0;
      if (last_rdy[1]) pl = 0;
      if (last_rdy[2]) pd = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
Name: regfile_wb_arb

Overview:
- Write-port arbiter for the core's 32x32 register file, which has one write port (wen/wraddr/wrdata, synchronous write, x0 not writable).
- Shares that port between three writeback sources: ALU/EX writeback, LSU load writeback and debug-module register write.
- Round-robin between ALU and LSU. Debug has the lowest priority, with a starvation guard.
- Output is registered and drives the register file write port directly.

Parameters:
- STARVE_MAX, 8: number of consecutive cycles debug may wait with dbg_valid high before it is force-granted. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must hold STARVE_MAX.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- alu_wb_valid  in  1  ALU write request
- alu_wb_addr  in  5  ALU destination register
- alu_wb_data  in  32  ALU result
- alu_wb_ready  out  1  ALU request accepted this cycle
- lsu_wb_valid  in  1  LSU load-data write request
- lsu_wb_addr  in  5  LSU destination register
- lsu_wb_data  in  32  load data
- lsu_wb_ready  out  1  LSU request accepted this cycle
- dbg_wb_valid  in  1  debug write request
- dbg_wb_addr  in  5  debug destination register
- dbg_wb_data  in  32  debug data
- dbg_wb_ready  out  1  debug request accepted this cycle
- wen  out  1  register-file write enable (registered)
- wraddr  out  5  register-file write address (registered)
- wrdata  out  32  register-file write data (registered)
- wb_conflict  out  1  registered pulse: more than one valid was present in the previous cycle

Behaviour:
- Handshake:
  - Transfer occurs when valid and ready are both high at a clk edge.
  - Ready is combinational from the valids and internal state, and is never asserted without the matching valid.
  - A requester holds valid/addr/data stable until accepted.
  - At most one ready is high per cycle.
- Grant selection, evaluated each cycle in this order:
  1. rst high: no ready asserted.
  2. force = (starve_cnt == STARVE_MAX) and dbg_wb_valid: grant debug.
  3. Both alu and lsu valid: grant the source not recorded in rr_last.
  4. Exactly one of alu/lsu valid: grant it.
  5. Only dbg valid: grant debug.
- rr_last:
  - 1-bit register; 0 means ALU was granted last, 1 means LSU.
  - Updated only on an ALU or LSU grant.
  - Reset value 1, so ALU wins the first tie.
- starve_cnt:
  - Reset 0. Cleared on a debug grant or when dbg_wb_valid is low.
  - Otherwise increments each cycle debug is valid but not granted, saturating at STARVE_MAX.
- Output latency is 1 cycle. At the edge where grant G is accepted:
  - wraddr <= G addr, wrdata <= G data.
  - wen <= 1 only if G addr != 0.
  - A grant to x0 consumes the slot and completes the handshake but produces wen = 0.
- No grant in a cycle: wen <= 0; wraddr/wrdata hold their previous values.
- Sustained throughput is one write per cycle. Back-to-back grants to the same or different sources produce back-to-back wen pulses.
- wb_conflict <= 1 when two or more of the three valids were high in the cycle; else 0.
- Reset values: wen 0, wraddr 0, wrdata 0, wb_conflict 0, rr_last 1, starve_cnt 0. All readies are 0 while rst is high.
- Reset mid-operation:
  - A request pending at reset is not accepted.
  - Any output write captured in the same cycle as rst is discarded, so wen is 0 after the edge.
  - Requesters must re-present after reset.
- Read-during-write bypass is handled by the register file itself; this block adds no forwarding.

Test Plan:
1. Reset, then ALU only with addr 5, data 0x11223344 -> alu_wb_ready=1 same cycle; next cycle wen=1, wraddr=5, wrdata=0x11223344.
2. ALU (addr 1, 0xA) and LSU (addr 2, 0xB) both held valid for 4 cycles after reset -> grants ALU, LSU, ALU, LSU. wen writes x1, x2, x1, x2 on consecutive cycles; wb_conflict=1 each following cycle.
3. Debug valid (addr 7, 0xDEAD) with ALU and LSU continuously valid, STARVE_MAX=8 -> dbg_wb_ready stays 0 for 8 cycles and rises on the 9th; the following cycle shows wraddr=7, wrdata=0xDEAD; starve_cnt then returns to 0.
4. LSU write to x0 with data 0xFFFFFFFF -> lsu_wb_ready=1; next cycle wen=0; a subsequent read of x0 returns 0.
5. rst asserted in the same cycle as an ALU request (addr 3) -> alu_wb_ready=0; after the edge wen=0 and wraddr=0; ALU holds valid and is accepted in the first cycle after rst drops.
6. Idle cycle between writes -> wen=0, wraddr/wrdata hold their last values, no spurious ready.
